// File: rtl/multiplier_unit_if.sv
// multiplier_unit_if: request, operand, external-adder and result signals of multiplier_unit
//   master: requester side; drives MUL_EN, MULOp, Operand1/2 and the adder Sum
//   slave : multiplier side; drives MAddInA/B, MCin, Result and Busy
interface multiplier_unit_if;
  logic        MUL_EN;
  logic        MULOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [31:0] Sum;
  logic [31:0] MAddInA;
  logic [31:0] MAddInB;
  logic        MCin;
  logic [31:0] Result;
  logic        Busy;
  modport master (
    output MUL_EN, MULOp, Operand1, Operand2, Sum,
    input  MAddInA, MAddInB, MCin, Result, Busy
  );
  modport slave (
    input  MUL_EN, MULOp, Operand1, Operand2, Sum,
    output MAddInA, MAddInB, MCin, Result, Busy
  );
endinterface

// File: rtl/multiplier_unit.sv
// multiplier_unit: 32x32 shift-add multiplier, one bit per cycle, using a shared external adder
//   CLK_MUL : clock, state updates on rising edge
//   Reset   : asynchronous active-high reset
//   mul     : multiplier_unit_if.slave (MUL_EN/MULOp/Operand1/Operand2/Sum in,
//             MAddInA/MAddInB/MCin/Result/Busy out)
//   MULTIPLIER_HIGH_WORD_EN: when defined, MULOp=1 returns the signed high word;
//   otherwise MULOp is ignored and Result is always the low word.
module multiplier_unit (
  input logic              CLK_MUL,
  input logic              Reset,
  multiplier_unit_if.slave mul
);
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        comp, start, last, sub, ext, hi_sel;
  logic [31:0] add_a, add_b;
  assign comp  = state_q == COMPUTE;
  assign start = state_q == IDLE && mul.MUL_EN;
  assign last  = cnt_q == 5'd31;
`ifdef MULTIPLIER_HIGH_WORD_EN
  logic op_q;
  logic c31;
  always_ff @(posedge CLK_MUL or posedge Reset)
    if (Reset) op_q <= 1'b0;
    else if (start) op_q <= mul.MULOp;
  // Final signed iteration weighs the multiplier sign bit negatively: add ~mcand + 1.
  assign sub    = comp && op_q && last && lo_q[0];
  // True bit 32 of the 33-bit signed sum: equals the common sign when the operand
  // signs agree, otherwise the inverse of the carry into bit 31.
  assign c31    = mul.Sum[31] ^ add_a[31] ^ add_b[31];
  assign ext    = op_q & ((add_a[31] & add_b[31]) | ((add_a[31] | add_b[31]) & ~c31));
  assign hi_sel = op_q;
`else
  assign sub    = 1'b0;
  assign ext    = 1'b0;
  assign hi_sel = 1'b0;
`endif
  assign add_a       = comp ? hi_q : 32'd0;
  assign add_b       = comp && lo_q[0] ? (sub ? ~mcand_q : mcand_q) : 32'd0;
  assign mul.MAddInA = add_a;
  assign mul.MAddInB = add_b;
  assign mul.MCin    = sub;
  assign mul.Result  = res_q;
  assign mul.Busy    = !Reset && (start || comp);
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: if (mul.MUL_EN) begin
        mcand_d = mul.Operand1;
        lo_d    = mul.Operand2;
        hi_d    = 32'd0;
        cnt_d   = 5'd0;
        state_d = COMPUTE;
      end
      COMPUTE: begin
        // {ext, Sum, lo} >> 1: the spent multiplier bit drops out of lo, product bits enter.
        hi_d  = {ext, mul.Sum[31:1]};
        lo_d  = {mul.Sum[0], lo_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          state_d = DONE;
          res_d   = hi_sel ? hi_d : lo_d;
        end
      end
      DONE: state_d = mul.MUL_EN ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK_MUL or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      mcand_q <= 32'd0;
      lo_q    <= 32'd0;
      hi_q    <= 32'd0;
      cnt_q   <= 5'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
endmodule

// File: tb/tb_multiplier_unit.sv
// tb_multiplier_unit: directed scoreboard bench for multiplier_unit with a modelled external adder
module tb_multiplier_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  multiplier_unit_if mif();
  always #5 clk = ~clk;
  assign mif.Sum = mif.MAddInA + mif.MAddInB + {31'd0, mif.MCin};
  multiplier_unit dut (.CLK_MUL(clk), .Reset(rst), .mul(mif));
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  int busy_n = 0;
  logic busy_p = 1'b0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] pick(input logic op, input logic [31:0] lo, input logic [31:0] hi);
`ifdef MULTIPLIER_HIGH_WORD_EN
    return op ? hi : lo;
`else
    return lo;
`endif
  endfunction
  // Monitor: counts COMPUTE cycles seen at negedges and checks Result when Busy falls.
  always @(negedge clk) begin
    if (rst) begin
      busy_p = 1'b0;
      busy_n = 0;
    end else begin
      if (mif.Busy) busy_n++;
      else if (busy_p) begin
        check("compute_cycles", busy_n, 32);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got %h, expected none", mif.Result);
        end else check("result", mif.Result, exp_q.pop_front());
        busy_n = 0;
      end
      busy_p = mif.Busy;
    end
  end
  task automatic wait_done();
    for (int k = 0; k < 40 && mif.Busy; k++) @(negedge clk);
    if (mif.Busy) begin
      tests++;
      fails++;
      $display("FAIL timeout: got Busy=1 after 40 cycles, expected 0");
    end
  endtask
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic op,
                     input logic [31:0] lo, input logic [31:0] hi, input bit hold);
    logic [31:0] e;
    e = pick(op, lo, hi);
    @(negedge clk);
    #1;
    mif.Operand1 = a;
    mif.Operand2 = b;
    mif.MULOp = op;
    mif.MUL_EN = 1'b1;
    exp_q.push_back(e);
    #1 check("busy_at_start", {31'd0, mif.Busy}, 32'd1);
    @(negedge clk);
    #1;
    mif.Operand1 = ~a;
    mif.Operand2 = b ^ 32'h5a5a_a5a5;
    mif.MULOp = ~op;
    wait_done();
    check("add_a_idle", mif.MAddInA, 32'd0);
    check("add_b_idle", mif.MAddInB, 32'd0);
    check("cin_idle", {31'd0, mif.MCin}, 32'd0);
    if (hold)
      repeat (3) begin
        @(negedge clk);
        check("no_restart", {31'd0, mif.Busy}, 32'd0);
      end
    #1 mif.MUL_EN = 1'b0;
    @(negedge clk);
    check("result_hold", mif.Result, e);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000ns, expected finish");
    $fatal(1);
  end
  initial begin
    mif.MUL_EN = 1'b1;
    mif.MULOp = 1'b0;
    mif.Operand1 = 32'd0;
    mif.Operand2 = 32'd0;
    #1;
    check("reset_busy", {31'd0, mif.Busy}, 32'd0);
    check("reset_result", mif.Result, 32'd0);
    check("reset_add_a", mif.MAddInA, 32'd0);
    mif.MUL_EN = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    run(32'h0000_0002, 32'h0000_0002, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b1);
    run(32'h0000_0002, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0);
    run(32'hFFFF_FFFE, 32'h0000_0002, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0);
    run(32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0);
    run(32'h0000_0002, 32'h0000_0002, 1'b1, 32'h0000_0004, 32'h0000_0000, 1'b0);
    run(32'h0000_0002, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0);
    run(32'hFFFF_FFFE, 32'h0000_0002, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0);
    run(32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b1, 32'h0000_0004, 32'h0000_0000, 1'b0);
    run(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 32'h4000_0000, 1'b0);
    run(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 32'h4000_0000, 1'b0);
    run(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0);
    run(32'h0000_0000, 32'h1234_5678, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
    run(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 32'hFFFE_0001, 32'h0000_0000, 1'b0);
    run(32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
    run(32'h1234_5678, 32'h0000_0010, 1'b1, 32'h2345_6780, 32'h0000_0001, 1'b0);
    run(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'h0000_0001, 32'h3FFF_FFFF, 1'b0);
    // Abort mid-operation: no expectation is queued for the aborted product.
    @(negedge clk);
    #1;
    mif.Operand1 = 32'h0000_0003;
    mif.Operand2 = 32'h0000_0005;
    mif.MULOp = 1'b0;
    mif.MUL_EN = 1'b1;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, mif.Busy}, 32'd0);
    check("abort_result", mif.Result, 32'd0);
    check("abort_add_a", mif.MAddInA, 32'd0);
    @(negedge clk);
    #1;
    mif.MUL_EN = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {31'd0, mif.Busy}, 32'd0);
    check("result_after_reset", mif.Result, 32'd0);
    run(32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
    run(32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_000F, 32'h0000_0000, 1'b1);
    run(32'hFFFF_FFFE, 32'h0000_0002, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL leftover: got %0d pending results, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multiplier_unit.md
MULTIPLIER_UNIT -- requirements
Module: Multiplier

Interface
REQ-001 The block SHALL use ports CLK_MUL, input, 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL use ports Reset, input, 1, an asynchronous active-high reset.
REQ-003 The block SHALL use ports MUL_EN, input, 1, the start request, level-sensitive.
REQ-004 The block SHALL use ports MULOp, input, 1: 0 selects the low word of the product (MUL); 1 selects the high word of the signed 64-bit product.
REQ-005 The block SHALL use ports Operand1, input, 32, the multiplicand, and Operand2, input, 32, the multiplier.
REQ-006 The block SHALL use ports Sum, input, 32, the result returned by the shared external 32-bit adder (Sum = MAddInA + MAddInB + MCin, mod 2^32).
REQ-007 The block SHALL use ports MAddInA, output, 32; MAddInB, output, 32; MCin, output, 1: the operands driven to the external adder.
REQ-008 The block SHALL use ports Result, output, 32, the selected product word, and Busy, output, 1, the stall indication.

Function
REQ-009 The block SHALL implement states IDLE, COMPUTE and DONE.
REQ-010 In IDLE, when MUL_EN=1 at a rising edge, the block SHALL latch Operand1, Operand2 and MULOp, clear the high accumulator and the iteration count, and enter COMPUTE.
REQ-011 Operands SHALL be sampled only at that edge; later changes SHALL be ignored until the next start.
REQ-012 COMPUTE SHALL last exactly 32 cycles, one multiplier bit per cycle, LSB first.
REQ-013 Each COMPUTE cycle SHALL drive MAddInA = high accumulator.
REQ-014 Each COMPUTE cycle SHALL drive MAddInB = multiplicand if the current multiplier bit is 1, else 0, with MCin = 0.
REQ-015 Exception to REQ-014: in signed mode (MULOp=1), iteration 31 with multiplier bit 31 set SHALL drive MAddInB = ~multiplicand with MCin = 1, i.e. subtract.
REQ-016 After each add, {extended bit, Sum, low register} SHALL be shifted right one place.
REQ-017 In signed mode the extended bit SHALL be the true 33rd sign bit, computed from MAddInA[31], MAddInB[31] and the carry into bit 31 (Sum[31]^MAddInA[31]^MAddInB[31]).
REQ-018 In unsigned/low mode the extended bit SHALL be 0; high-word overflow is irrelevant there.
REQ-019 After the 32nd cycle the block SHALL enter DONE.
REQ-020 In DONE, Result SHALL equal the low word (MULOp=0) or the high word (MULOp=1) and SHALL hold until the next start.
REQ-021 In DONE the block SHALL remain until MUL_EN=0 at an edge, then return to IDLE; a held-high MUL_EN SHALL NOT restart the operation.
REQ-022 Busy SHALL be combinational: 1 when (IDLE and MUL_EN=1) or in COMPUTE; 0 in DONE and otherwise.
REQ-023 Latency SHALL be 33 rising edges from the first edge seeing MUL_EN=1 to Busy=0.
REQ-024 Outside COMPUTE, MAddInA, MAddInB and MCin SHALL all be 0.
REQ-025 Operand values 0 and 0x80000000 SHALL give correct results with no special-casing.

Reset
REQ-026 Reset=1 SHALL immediately force state IDLE, Result = 0, accumulators and count = 0, and Busy = 0, regardless of MUL_EN.
REQ-027 Reset during COMPUTE SHALL abort the operation, with no partial result exposed.
REQ-028 After release, a new start SHALL require MUL_EN=1 at an edge.

Configuration
REQ-029 With macro MULTIPLIER_HIGH_WORD_EN defined, MULOp SHALL behave as in REQ-004 and REQ-015.
REQ-030 Without MULTIPLIER_HIGH_WORD_EN, MULOp SHALL be ignored, Result SHALL always be the low word, and the signed extended-bit and subtract logic SHALL be omitted.

Verification (MULTIPLIER_HIGH_WORD_EN defined)
REQ-031 MULOp=0, 0x00000002 x 0x00000002, MUL_EN held 35 cycles -> Busy high for 33 edges, then Result=0x00000004.
REQ-032 MULOp=0 -> Result=0xFFFFFFFC for 0x00000002 x 0xFFFFFFFE and for 0xFFFFFFFE x 0x00000002; Result=0x00000004 for 0xFFFFFFFE x 0xFFFFFFFE.
REQ-033 MULOp=1 -> Result=0x00000000 for 2x2, 0xFFFFFFFF for 2x(-2) and for (-2)x2, and 0x00000000 for (-2)x(-2).
REQ-034 MULOp=1, 0x80000000 x 0x80000000 -> Result=0x40000000; MULOp=0 on the same operands -> Result=0x00000000.
REQ-035 Reset pulsed at COMPUTE cycle 10 -> Busy=0 and Result=0 immediately; a restart yields the correct product.
REQ-036 MUL_EN held high beyond DONE -> no restart and Busy stays 0; MUL_EN low then high -> a new 33-edge operation.
